lut_frac4_serial: RTL
=====================

LUT_FRAC4_SERIAL -- requirements
Module: lut_frac4_serial

Interface
REQ-001 SHALL have parameter INPUTS, default 4, meaning sub-LUT input count (legal range 3..6).
REQ-002 SHALL have parameter MEM_SIZE, default 2**INPUTS, meaning bits per sub-LUT (M).
REQ-003 SHALL have parameter CFG_BITS, default 4*MEM_SIZE+6, meaning total configuration word length.
REQ-004 SHALL have ports: cclk  input  1  sole clock, rising edge; all state changes on this edge.
REQ-005 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: addr  input  4*INPUTS  four address groups; group g = addr[g*INPUTS +: INPUTS].
REQ-007 SHALL have ports: out  output  4  LUT outputs, one per group.
REQ-008 SHALL have ports: cfg_start  input  1  pulse that begins a new serial load.
REQ-009 SHALL have ports: cfg_we  input  1  qualifies cfg_in.
REQ-010 SHALL have ports: cfg_in  input  1  serial configuration bit.
REQ-011 SHALL have ports: cfg_busy  output  1  high while a load is in progress.
REQ-012 SHALL have ports: cfg_done  output  1  one-cycle pulse on commit.
REQ-013 SHALL have ports: cfg_valid  output  1  high once a configuration has been committed.

Function
REQ-014 SHALL hold a shadow shift register (CFG_BITS) and an active config register (CFG_BITS); layout MSB to LSB: mode[1:0], reg_en[3:0], mem[4M-1:0].
REQ-015 SHALL shift with shadow <= {shadow[CFG_BITS-2:0], cfg_in} on every cycle in LOAD with cfg_we=1; the first bit shifted ends up at the MSB.
REQ-016 SHALL implement FSM EMPTY -> LOAD (cfg_start) -> COMMIT (bit count reaches CFG_BITS) -> ACTIVE; cfg_start in ACTIVE -> LOAD; cfg_start in LOAD restarts the count at 0.
REQ-017 SHALL, in COMMIT, copy shadow to active in one cycle, assert cfg_done for exactly that cycle, set cfg_valid, then go to ACTIVE.
REQ-018 SHALL ignore cfg_we in EMPTY, COMMIT and ACTIVE; cfg_start in COMMIT is ignored.
REQ-019 SHALL, when cfg_start and cfg_we occur in the same cycle, count that cycle's bit as the first bit of the new load.
REQ-020 SHALL assert cfg_busy in LOAD and COMMIT only.
REQ-021 SHALL keep the previous active config driving the outputs unchanged during a reload until the COMMIT cycle (no glitch); cfg_valid stays high through reload.
REQ-022 SHALL decode mode as follows. 0 FULL: out[0] = mem[addr[INPUTS+1:0]], out[3:1]=0.
REQ-023 SHALL decode mode 1 HALF: out[0] = mem[addr[INPUTS:0]]; out[2] = mem[2M + {addr[3*INPUTS], addr[3*INPUTS-1:2*INPUTS]}]; out[1]=out[3]=0.
REQ-024 SHALL decode mode 2 QUARTER: out[g] = mem[g*M + group g], for g=0..3.
REQ-025 SHALL decode mode 3 (reserved) as all comb outputs 0.
REQ-026 SHALL force every comb output to 0 while cfg_valid=0.
REQ-027 SHALL, for each g, drive out[g] from a register sampling the comb value each cycle when reg_en[g]=1 (one-cycle latency); when reg_en[g]=0, out[g] is combinational (zero latency).
REQ-028 SHALL update output registers every cycle, including during LOAD; after COMMIT the new config takes effect the next cycle for comb outputs and one cycle later for registered outputs.

Reset
REQ-029 SHALL, on rst=1 at a cclk edge, set FSM=EMPTY, bit count=0, shadow=0, active=0, all output registers=0, cfg_busy=0, cfg_done=0, cfg_valid=0, out=4'b0.
REQ-030 SHALL, when rst is asserted mid-load, discard the partial load and any previous configuration; rst has priority over cfg_start.

Verification
REQ-031 SHALL cover: reset, then addr sweep with no load -> out=0 and cfg_valid=0 throughout.
REQ-032 SHALL cover (INPUTS=4, 70 bits): load mode=2, reg_en=0, mem=pattern with sub-LUT g = 16'hA5A5 rotated left by g -> cfg_done pulses on exactly the cycle after the 70th bit; each out[g] matches its sub-LUT over all 16 addresses.
REQ-033 SHALL cover: mode=0, mem[63:0]=one-hot at index 37 -> out[0]=1 only for addr[5:0]=37; out[3:1]=0.
REQ-034 SHALL cover: mode=1 with reg_en=4'b0001 -> out[0] lags the addr change by one cycle; out[2] is same-cycle; out[1]=out[3]=0.
REQ-035 SHALL cover: reload with a different pattern, pausing cfg_we, and asserting cfg_start mid-load -> out keeps the old function until the commit cycle; the count restarts at cfg_start.
REQ-036 SHALL cover: rst asserted after 40 of 70 bits -> cfg_valid=0, out=0, and a subsequent full load commits correctly.

Source files
------------

// File: rtl/lut_frac4_serial.sv
// Fracturable 4-way LUT. Configuration arrives serially into a shadow register
// and is committed atomically, so a reload never disturbs the live function.
module lut_frac4_serial #(
  parameter int unsigned INPUTS   = 4,
  parameter int unsigned MEM_SIZE = 2**INPUTS,
  parameter int unsigned CFG_BITS = 4*MEM_SIZE+6
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic [4*INPUTS-1:0]   addr,
  output logic [3:0]            out,
  input  logic                  cfg_start,
  input  logic                  cfg_we,
  input  logic                  cfg_in,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_valid
);

  localparam int unsigned AW    = INPUTS + 2;
  localparam int unsigned MW    = 4 * MEM_SIZE;
  localparam int unsigned CNT_W = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_COMMIT, S_ACTIVE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 shift_en;
  logic [CFG_BITS-1:0]  shadow, active;
  logic [3:0]           out_q, out_c;

  logic [1:0]           mode;
  logic [3:0]           reg_en;
  logic [MW-1:0]        mem;

  assign mode   = active[CFG_BITS-1 -: 2];
  assign reg_en = active[CFG_BITS-3 -: 4];
  assign mem    = active[MW-1:0];

  // Next-state: cfg_start (re)opens a load; a same-cycle cfg_we bit is bit one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    case (state)
      S_EMPTY, S_ACTIVE: begin
        if (cfg_start) begin
          state_nxt = S_LOAD;
          shift_en  = cfg_we;
          cnt_nxt   = cfg_we ? CNT_W'(1) : '0;
        end
      end
      S_LOAD: begin
        if (cfg_start) begin
          shift_en = cfg_we;
          cnt_nxt  = cfg_we ? CNT_W'(1) : '0;
        end else if (cfg_we) begin
          shift_en = 1'b1;
          if (cnt == CNT_W'(CFG_BITS - 1)) begin
            state_nxt = S_COMMIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_COMMIT: state_nxt = S_ACTIVE;
      default:  state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state     <= S_EMPTY;
      cnt       <= '0;
      shadow    <= '0;
      active    <= '0;
      out_q     <= '0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_q     <= out_c;
      cfg_busy  <= (state_nxt == S_LOAD) || (state_nxt == S_COMMIT);
      cfg_done  <= (state_nxt == S_COMMIT);
      if (shift_en)
        shadow <= {shadow[CFG_BITS-2:0], cfg_in};
      if (state == S_COMMIT) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
      end
    end
  end

  // Mode decode of the committed memory image.
  always_comb begin
    out_c = '0;
    case (mode)
      2'd0: out_c[0] = mem[addr[INPUTS+1:0]];
      2'd1: begin
        out_c[0] = mem[AW'(addr[INPUTS:0])];
        out_c[2] = mem[AW'(2*MEM_SIZE) +
                       AW'({addr[3*INPUTS], addr[3*INPUTS-1:2*INPUTS]})];
      end
      2'd2: begin
        for (int g = 0; g < 4; g++)
          out_c[g] = mem[AW'(g*MEM_SIZE) + AW'(addr[g*INPUTS +: INPUTS])];
      end
      default: out_c = '0;
    endcase
    if (!cfg_valid)
      out_c = '0;
  end

  assign out = (reg_en & out_q) | (~reg_en & out_c);

endmodule
